// File: rtl/hist_buf_search_if.sv
// Bus bundle for hist_buf_search: sample write, registered read-back and search request/result.
// srch_mask exists only when HIST_BUF_MASK_EN is defined.
interface hist_buf_search_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      fill;
  logic             full;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             srch_valid;
  logic             srch_ready;
  logic [WIDTH-1:0] srch_key;
`ifdef HIST_BUF_MASK_EN
  logic [WIDTH-1:0] srch_mask;
`endif
  logic             res_valid;
  logic             res_hit;
  logic [AW-1:0]    res_idx;

`ifdef HIST_BUF_MASK_EN
  modport master (
    output wr_en, wr_data, rd_idx, srch_valid, srch_key, srch_mask,
    input  wr_ptr, fill, full, rd_data, srch_ready, res_valid, res_hit, res_idx
  );
  modport slave (
    input  wr_en, wr_data, rd_idx, srch_valid, srch_key, srch_mask,
    output wr_ptr, fill, full, rd_data, srch_ready, res_valid, res_hit, res_idx
  );
`else
  modport master (
    output wr_en, wr_data, rd_idx, srch_valid, srch_key,
    input  wr_ptr, fill, full, rd_data, srch_ready, res_valid, res_hit, res_idx
  );
  modport slave (
    input  wr_en, wr_data, rd_idx, srch_valid, srch_key,
    output wr_ptr, fill, full, rd_data, srch_ready, res_valid, res_hit, res_idx
  );
`endif
endinterface

// File: rtl/hist_buf_search.sv
// Circular history buffer with fill tracking, registered read-back and a sequential
// membership search engine. Optional compare mask enabled by HIST_BUF_MASK_EN.
module hist_buf_search #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  hist_buf_search_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  function automatic logic key_match(input logic [WIDTH-1:0] data,
                                     input logic [WIDTH-1:0] key,
                                     input logic [WIDTH-1:0] mask);
    return (((data ^ key) & mask) == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      fill_r;
  logic             full_r;
  logic [WIDTH-1:0] rd_data_r;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] key_r;
  logic [WIDTH-1:0] mask_s;
  logic [AW:0]      lim_r;
  logic [AW-1:0]    scan_idx_r;
  logic             hit_r;
  logic [AW-1:0]    hit_idx_r;
  logic             srch_ready_r;
  logic             res_valid_r;
  logic             res_hit_r;
  logic [AW-1:0]    res_idx_r;
  logic             accept_s;
  logic             match_s;
  logic             last_s;

`ifdef HIST_BUF_MASK_EN
  logic [WIDTH-1:0] mask_r;
  assign mask_s = mask_r;
`else
  assign mask_s = {WIDTH{1'b1}};
`endif

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Write pointer, fill level and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      fill_r    <= {(AW+1){1'b0}};
      full_r    <= 1'b0;
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[bus.rd_idx];
      if (bus.wr_en) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        if (!full_r) begin
          fill_r <= fill_r + (AW+1)'(1'b1);
          full_r <= (fill_r == (FILL_MAX - (AW+1)'(1'b1)));
        end
      end
    end
  end

  // Search next-state; compare sees the pre-write contents of the scanned entry.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    match_s  = key_match(mem_r[scan_idx_r], key_r, mask_s);
    last_s   = ({1'b0, scan_idx_r} == (lim_r - (AW+1)'(1'b1)));
    case (state_r)
      IDLE: begin
        if (bus.srch_valid && srch_ready_r) begin
          accept_s = 1'b1;
          if (fill_r != {(AW+1){1'b0}}) begin
            state_s = SCAN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (match_s || last_s) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Search state, request latch, scan progress and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      key_r        <= {WIDTH{1'b0}};
`ifdef HIST_BUF_MASK_EN
      mask_r       <= {WIDTH{1'b0}};
`endif
      lim_r        <= {(AW+1){1'b0}};
      scan_idx_r   <= {AW{1'b0}};
      hit_r        <= 1'b0;
      hit_idx_r    <= {AW{1'b0}};
      srch_ready_r <= 1'b1;
      res_valid_r  <= 1'b0;
      res_hit_r    <= 1'b0;
      res_idx_r    <= {AW{1'b0}};
    end else begin
      state_r      <= state_s;
      // Ready stays low through the result cycle, so it returns the cycle after.
      srch_ready_r <= (state_s == IDLE) && (state_r != DONE);
      res_valid_r  <= (state_r == DONE);
      if (state_r == DONE) begin
        res_hit_r <= hit_r;
        res_idx_r <= hit_idx_r;
      end
      if (accept_s) begin
        key_r      <= bus.srch_key;
`ifdef HIST_BUF_MASK_EN
        mask_r     <= bus.srch_mask;
`endif
        lim_r      <= fill_r;
        scan_idx_r <= {AW{1'b0}};
        hit_r      <= 1'b0;
        hit_idx_r  <= {AW{1'b0}};
      end else if (state_r == SCAN) begin
        if (match_s) begin
          hit_r     <= 1'b1;
          hit_idx_r <= scan_idx_r;
        end else begin
          scan_idx_r <= scan_idx_r + AW'(1'b1);
        end
      end
    end
  end

  assign bus.wr_ptr     = wr_ptr_r;
  assign bus.fill       = fill_r;
  assign bus.full       = full_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.srch_ready = srch_ready_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_hit    = res_hit_r;
  assign bus.res_idx    = res_idx_r;
endmodule

// File: tb/tb_hist_buf_search.sv
// Self-checking bench for hist_buf_search: reference buffer model plus a result scoreboard.
module tb_hist_buf_search;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   cyc;
  int   acc_edge;
  int   res_count;
  logic prev_rv;
  exp_t sb[$];

  logic [7:0] mmem [DEPTH];
  int         mptr;
  int         mfill;

  hist_buf_search_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  hist_buf_search #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_total = n_total + 1;
    if (obs == exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Result monitor: pops the scoreboard on each result pulse, checks pulse shape and ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_rv) begin
        check("res_one_cycle", int'(bus.res_valid), 0);
        check("ready_after_res", int'(bus.srch_ready), 1);
      end
      if (bus.res_valid) begin
        res_count = res_count + 1;
        check("ready_low_at_res", int'(bus.srch_ready), 0);
        if (sb.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_hit", int'(bus.res_hit), int'(e.hit));
          check("res_idx", int'(bus.res_idx), int'(e.idx));
          check("res_latency", cyc - acc_edge, e.lat);
        end
      end
      if (bus.srch_valid && bus.srch_ready) acc_edge = cyc + 1;
      prev_rv = bus.res_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    mptr  = 0;
    mfill = 0;
    sb.delete();
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick;
    bus.wr_en   = 1'b0;
    mmem[mptr]  = d;
    mptr        = (mptr + 1) % DEPTH;
    if (mfill < DEPTH) mfill = mfill + 1;
  endtask

  task automatic do_search(input logic [7:0] key, input logic [7:0] mask, input int hold);
    exp_t       e;
    logic [7:0] eff_mask;
    int         waited;
`ifdef HIST_BUF_MASK_EN
    eff_mask      = mask;
    bus.srch_mask = mask;
`else
    eff_mask      = 8'hFF;
`endif
    e.hit = 1'b0;
    e.idx = 4'd0;
    e.lat = (mfill == 0) ? 1 : mfill + 1;
    for (int i = 0; i < mfill; i++) begin
      if (((mmem[i] ^ key) & eff_mask) == 8'h00) begin
        e.hit = 1'b1;
        e.idx = 4'(i);
        e.lat = i + 2;
        break;
      end
    end
    bus.srch_key   = key;
    bus.srch_valid = 1'b1;
    waited = 0;
    while (!bus.srch_ready && waited < 50) begin
      tick;
      waited = waited + 1;
    end
    if (!bus.srch_ready) check("ready_timeout", 0, 1);
    sb.push_back(e);
    tick;
    for (int i = 0; i < hold; i++) tick;
    bus.srch_valid = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick;
    check("sb_drain", sb.size(), 0);
    tick;
    tick;
  endtask

  initial begin
    int rc;
    n_pass = 0; n_total = 0; cyc = 0; acc_edge = 0; res_count = 0; prev_rv = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_idx = 4'd0;
    bus.srch_valid = 1'b0; bus.srch_key = 8'h00;
`ifdef HIST_BUF_MASK_EN
    bus.srch_mask = 8'hFF;
`endif
    rst_n = 1'b0;
    mptr = 0; mfill = 0;
    tick;
    check("rst_wr_ptr", int'(bus.wr_ptr), 0);
    check("rst_fill", int'(bus.fill), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_ready", int'(bus.srch_ready), 1);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_hit", int'(bus.res_hit), 0);
    check("rst_res_idx", int'(bus.res_idx), 0);
    tick;
    rst_n = 1'b1;
    tick;

    // Empty buffer search: one-cycle latency, miss.
    do_search(8'h00, 8'hFF, 0);
    wait_done();

    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    check("fill6", int'(bus.fill), 6);
    check("wr_ptr6", int'(bus.wr_ptr), 6);
    check("full6", int'(bus.full), 0);
    bus.rd_idx = 4'd3;
    tick;
    check("rd_data3", int'(bus.rd_data), 8'h13);

    do_search(8'h13, 8'hFF, 0);
    wait_done();
    do_search(8'h99, 8'hFF, 0);
    wait_done();
    do_search(8'h10, 8'hFF, 0);
    wait_done();
    do_search(8'h15, 8'hFF, 0);
    wait_done();

    // Request held through the scan must be taken only once.
    rc = res_count;
    do_search(8'h99, 8'hFF, 4);
    wait_done();
    for (int i = 0; i < 8; i++) tick;
    check("held_valid_once", res_count - rc, 1);

    // Reset in the middle of a scan aborts without a result.
    bus.srch_key   = 8'h99;
    bus.srch_valid = 1'b1;
    tick;
    bus.srch_valid = 1'b0;
    tick;
    tick;
    rc = res_count;
    #2;
    rst_n = 1'b0;
    mptr = 0; mfill = 0;
    sb.delete();
    #1;
    check("abort_ready", int'(bus.srch_ready), 1);
    check("abort_fill", int'(bus.fill), 0);
    check("abort_res_valid", int'(bus.res_valid), 0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check("abort_no_result", res_count - rc, 0);

    for (int i = 0; i < 20; i++) wr(8'(i));
    check("fill_sat", int'(bus.fill), 16);
    check("full_set", int'(bus.full), 1);
    check("wr_ptr_wrap", int'(bus.wr_ptr), 4);
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 4'(i);
      tick;
      check("rd_overwritten", int'(bus.rd_data), 8'h10 + i);
    end
    do_search(8'h01, 8'hFF, 0);
    wait_done();
    do_search(8'h12, 8'hFF, 0);
    wait_done();
    do_search(8'h0F, 8'hFF, 0);
    wait_done();

    // Same-cycle write to the read address returns the old value.
    bus.rd_idx = 4'd4;
    wr(8'h77);
    check("rd_old_on_write", int'(bus.rd_data), 8'h04);
    tick;
    check("rd_new_after_write", int'(bus.rd_data), 8'h77);
    check("fill_stays_full", int'(bus.fill), 16);

`ifdef HIST_BUF_MASK_EN
    do_reset();
    wr(8'hA5);
    do_search(8'hAF, 8'hF0, 0);
    wait_done();
    do_search(8'hAF, 8'hFF, 0);
    wait_done();
    do_search(8'h00, 8'h00, 0);
    wait_done();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/hist_buf_search.md
# hist_buf_search

Parametrised circular history buffer with a sequential membership search engine. It captures a stream of WIDTH-bit samples into DEPTH entries with wrap-around overwrite, tracks fill level, and supports registered random read-back. It answers "is key present among the stored entries?" queries through a valid/ready request and a one-cycle result pulse. It sits after the sample capture path and serves pattern/membership checks on recent history.

## Interface
- WIDTH, 8, sample width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AW, $clog2(DEPTH), derived index width; not to be overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write wr_data at wr_ptr this cycle
- wr_data  input  WIDTH  sample to store
- wr_ptr  output  AW  next write address
- fill  output  AW+1  valid entry count, 0..DEPTH
- full  output  1  fill == DEPTH
- rd_idx  input  AW  absolute read address
- rd_data  output  WIDTH  mem[rd_idx], registered
- srch_valid  input  1  search request
- srch_ready  output  1  engine idle, request accepted when both high
- srch_key  input  WIDTH  value searched for
- srch_mask  input  WIDTH  compare mask, 1 = bit compared (present only with HIST_BUF_MASK_EN)
- res_valid  output  1  one-cycle result pulse
- res_hit  output  1  key found
- res_idx  output  AW  lowest matching address; 0 when no hit

## Operation
- Write: on wr_en, mem[wr_ptr] <= wr_data, wr_ptr <= wr_ptr+1 modulo DEPTH (wraps DEPTH-1 -> 0). fill increments, saturating at DEPTH; when full, writes overwrite oldest entry, fill stays DEPTH.
- Read: rd_data <= mem[rd_idx] every cycle; a same-cycle write to rd_idx returns the old value.
- Search FSM states: IDLE, SCAN, DONE.
  - IDLE: srch_ready=1. On srch_valid: latch key (and mask), snapshot fill as lim, scan_idx <= 0; go SCAN if lim>0, else DONE with hit=0.
  - SCAN: compare mem[scan_idx] to key. Match -> hit=1, res_idx=scan_idx, DONE. No match and scan_idx==lim-1 -> hit=0, DONE. Otherwise scan_idx+1.
  - DONE: res_valid=1 for exactly one cycle, res_hit/res_idx valid that cycle and held until next DONE; then IDLE.
- Scanned range is absolute addresses 0..lim-1 (full buffer covers all DEPTH entries).
- Writes are allowed during SCAN; comparison uses current memory contents (pre-write value when writing the address under compare that cycle). lim is not updated by writes during a scan.
- srch_valid while not IDLE is ignored (not queued).

## Timing
- Reset (rst_n low, asynchronous): wr_ptr=0, fill=0, full=0, rd_data=0, FSM=IDLE, srch_ready=1, res_valid=0, res_hit=0, res_idx=0. Memory contents not reset. Reset mid-scan aborts the scan with no res_valid pulse.
- rd_data latency: 1 cycle.
- Search latency from accepting edge: hit at address k -> res_valid k+2 cycles later; miss -> lim+1 cycles; lim==0 -> 1 cycle.
- srch_ready returns high the cycle after res_valid; back-to-back searches therefore have one idle cycle between result and next acceptance minimum.
- fill/full/wr_ptr update on the edge following wr_en.

## Configuration
- HIST_BUF_MASK_EN defined: srch_mask port exists, latched with key; match = ((mem ^ key) & mask) == 0. Mask of all zeros matches first valid entry.
- Undefined: no srch_mask port; match is full-width equality.

## Test plan
- Reset then write 0x10,0x11,...,0x15 (6 writes) -> fill=6, wr_ptr=6, full=0; rd_idx=3 -> rd_data=0x13 one cycle later.
- Search key 0x13 on that state -> res_valid 5 cycles after acceptance, res_hit=1, res_idx=3; key 0x99 -> res_valid 7 cycles after, res_hit=0, res_idx=0.
- Write 20 samples 0x00..0x13 -> fill=16, full=1, wr_ptr=4, mem[0..3]=0x10..0x13; search 0x01 -> miss; search 0x12 -> hit, res_idx=2.
- Search immediately after reset (fill=0) -> res_valid 1 cycle after acceptance, res_hit=0; srch_valid held during SCAN is not accepted a second time.
- Assert rst_n low during SCAN -> no res_valid, fill=0, srch_ready=1 immediately.
- With HIST_BUF_MASK_EN: store 0xA5, search key 0xAF mask 0xF0 -> hit idx 0; mask 0xFF -> miss.
